// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IR capture and one-cycle-penalty redirects.
// Supports JR, J/JAL, conditional branch, hazard stall and a halt opcode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Jal,
    input  logic        And,
    input  logic        AluZero,
    input  logic [31:0] RegAddr,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    output logic [31:0] ir_pc_plus4,
    output logic        ir_valid,
    output logic        ra_write,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir_pc;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        active;
    logic        halt_hit;
    logic        taken;
    logic        redirect;

    assign instr_addr  = pc;
    assign ir_pc_plus4 = ir_pc + 32'd4;

    // Flags only mean something for a real instruction in RUN with no hazard.
    assign active   = ir_valid & ~stall & (state == RUN);
    assign halt_hit = active & (instr_out[31:26] == HALT_OPCODE);
    assign taken    = And & AluZero;
    assign redirect = active & (JumpReg | Jump | taken);
    assign ra_write = active & Jal & Jump;

    assign br_off = {{14{instr_out[15]}}, instr_out[15:0], 2'b00};

    always_comb begin
        next_pc = pc + 32'd4;
        if (JumpReg)
            next_pc = RegAddr & ~32'd3;
        else if (Jump)
            next_pc = {ir_pc_plus4[31:28], instr_out[25:0], 2'b00};
        else if (taken)
            next_pc = ir_pc_plus4 + br_off;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            instr_out <= 32'd0;
            ir_pc     <= 32'd0;
            ir_valid  <= 1'b0;
            state     <= RUN;
            halted    <= 1'b0;
        end else if (state == RUN && !stall) begin
            if (halt_hit) begin
                state     <= HALT;
                halted    <= 1'b1;
                instr_out <= 32'd0;
                ir_valid  <= 1'b0;
            end else if (redirect) begin
                // Sequential word fetched this cycle is squashed.
                pc        <= next_pc;
                instr_out <= 32'd0;
                ir_valid  <= 1'b0;
            end else begin
                instr_out <= instr_in;
                ir_pc     <= pc;
                ir_valid  <= 1'b1;
                pc        <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random flags against a
// program-counter level reference model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        Jump = 1'b0, JumpReg = 1'b0, Jal = 1'b0;
    logic        And = 1'b0, AluZero = 1'b0;
    logic [31:0] RegAddr = 32'd0;
    logic [31:0] instr_in;
    logic [31:0] instr_addr, instr_out, ir_pc_plus4;
    logic        ir_valid, ra_write, halted;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] patch [logic [31:0]];

    logic [31:0] m_pc, m_ir, m_irpc;
    logic        m_valid, m_halt;
    logic        got_ra, want_ra;
    logic [31:0] got_p4;

    instr_fetch dut (
        .clock(clock), .reset(reset), .stall(stall),
        .Jump(Jump), .JumpReg(JumpReg), .Jal(Jal),
        .And(And), .AluZero(AluZero), .RegAddr(RegAddr),
        .instr_in(instr_in), .instr_addr(instr_addr),
        .instr_out(instr_out), .ir_pc_plus4(ir_pc_plus4),
        .ir_valid(ir_valid), .ra_write(ra_write), .halted(halted)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [31:0] w;
        if (patch.exists(a)) return patch[a];
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    assign instr_in = imem(instr_addr);

    // Drive one cycle's inputs, advance the model, step the clock.
    task automatic cycle(input logic s, j, jr, jal, an, az,
                         input logic [31:0] ra);
        int off;
        logic [31:0] seq;
        stall = s; Jump = j; JumpReg = jr; Jal = jal;
        And = an; AluZero = az; RegAddr = ra;
        #1;
        got_ra  = ra_write;
        got_p4  = ir_pc_plus4;
        want_ra = m_valid && !m_halt && !s && jal && j;
        if (!m_halt && !s) begin
            if (m_valid && m_ir[31:26] == 6'h3F) begin
                m_halt = 1'b1; m_ir = 32'd0; m_valid = 1'b0;
            end else if (m_valid && (jr || j || (an && az))) begin
                off = int'($signed(m_ir[15:0]));
                seq = m_irpc + 32'd4;
                if (jr)      m_pc = {ra[31:2], 2'b00};
                else if (j)  m_pc = {seq[31:28], m_ir[25:0], 2'b00};
                else         m_pc = seq + 32'(off * 4);
                m_ir = 32'd0; m_valid = 1'b0;
            end else begin
                m_ir = imem(m_pc); m_irpc = m_pc;
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0;
        Jump = 0; JumpReg = 0; Jal = 0; And = 0; AluZero = 0;
        m_pc = 32'd0; m_ir = 32'd0; m_irpc = 32'd0;
        m_valid = 1'b0; m_halt = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        patch.delete();
        @(negedge clock);
        #1;
        if ({instr_addr, instr_out} !== 64'd0 || ir_valid !== 1'b0 ||
            halted !== 1'b0 || ra_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got addr=%h ir=%h v=%b h=%b ra=%b want zeros",
                     instr_addr, instr_out, ir_valid, halted, ra_write);
        end
        vectors++;
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Assert reset with a redirect pending.
        Jump = 1; JumpReg = 1; Jal = 1; RegAddr = 32'h400;
        #2 reset = 1'b1;
        #1;
        if (instr_addr !== 32'd0 || halted !== 1'b0 || ra_write !== 1'b0 ||
            ir_valid !== 1'b0 || instr_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async got addr=%h v=%b ra=%b want 0/0/0",
                     instr_addr, ir_valid, ra_write);
        end
        vectors++;
        @(negedge clock);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        if (instr_addr !== 32'd4 || ir_valid !== 1'b1 ||
            ir_pc_plus4 !== 32'd4 || instr_out !== imem(32'd0)) begin
            miscompares++;
            $display("FAIL reset_first_fetch got addr=%h v=%b p4=%h want 4/1/4",
                     instr_addr, ir_valid, ir_pc_plus4);
        end
        vectors++;
    endtask

    task automatic test_sequential();
        patch.delete();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (instr_addr !== 32'(4 * k) || ir_valid !== 1'b1 ||
                ir_pc_plus4 !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL seq_%0d got addr=%h v=%b p4=%h want %h/1/%h",
                         k, instr_addr, ir_valid, ir_pc_plus4, 4 * k, 4 * k);
            end
            vectors++;
        end
    endtask

    task automatic test_branch();
        patch.delete();
        patch[32'h10] = 32'h1000_FFFE;
        do_reset();
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        if (instr_addr !== 32'h0C || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_taken got addr=%h v=%b want 0c/0",
                     instr_addr, ir_valid);
        end
        vectors++;
        cycle(0, 0, 0, 0, 1, 1, 0);
        if (instr_addr !== 32'h10 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_bubble_ignored got addr=%h v=%b want 10/1",
                     instr_addr, ir_valid);
        end
        vectors++;
        do_reset();
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        if (instr_addr !== 32'h18 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_not_taken got addr=%h v=%b want 18/1",
                     instr_addr, ir_valid);
        end
        vectors++;
    endtask

    task automatic test_jal();
        patch.delete();
        patch[32'h20] = 32'h0C00_0040;
        do_reset();
        repeat (9) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 0);
        if (got_ra !== 1'b1 || got_p4 !== 32'h24) begin
            miscompares++;
            $display("FAIL jal_ra got ra=%b p4=%h want 1/24", got_ra, got_p4);
        end
        vectors++;
        if (instr_addr !== 32'h100 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL jal_target got addr=%h v=%b want 100/0",
                     instr_addr, ir_valid);
        end
        vectors++;
        cycle(0, 1, 0, 1, 0, 0, 0);
        if (got_ra !== 1'b0 || instr_addr !== 32'h104 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_once got ra=%b addr=%h v=%b want 0/104/1",
                     got_ra, instr_addr, ir_valid);
        end
        vectors++;
    endtask

    task automatic test_jumpreg();
        patch.delete();
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 1, 1, 32'h203);
        if (instr_addr !== 32'h200 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL jr_priority got addr=%h v=%b want 200/0",
                     instr_addr, ir_valid);
        end
        vectors++;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);
        cycle(0, 0, 0, 0, 0, 0, 0);
        if (instr_addr !== 32'd0 || ir_pc_plus4 !== 32'd0 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pc_wrap got addr=%h p4=%h v=%b want 0/0/1",
                     instr_addr, ir_pc_plus4, ir_valid);
        end
        vectors++;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        patch.delete();
        patch[32'h10] = 32'h1000_FFFE;
        do_reset();
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 0);
        held = instr_out;
        for (int k = 0; k < 2; k++) begin
            cycle(1, 1, 0, 1, 1, 1, 0);
            if (instr_addr !== 32'h14 || instr_out !== held ||
                ir_valid !== 1'b1 || got_ra !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold_%0d got addr=%h ir=%h ra=%b want 14/%h/0",
                         k, instr_addr, instr_out, got_ra, held);
            end
            vectors++;
        end
        cycle(0, 0, 0, 0, 1, 1, 0);
        if (instr_addr !== 32'h0C || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release got addr=%h v=%b want 0c/0",
                     instr_addr, ir_valid);
        end
        vectors++;
        cycle(0, 0, 0, 0, 1, 1, 0);
        if (instr_addr !== 32'h10 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_once got addr=%h v=%b want 10/1",
                     instr_addr, ir_valid);
        end
        vectors++;
    endtask

    task automatic test_random();
        int r;
        logic s, j, jr, jal, an, az;
        patch.delete();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 11));
            s  = ($urandom_range(0, 3) == 0);
            jr = (r == 0);
            j  = (r == 1 || r == 2);
            jal = (r == 2 || r == 6);
            an = (r == 3 || r == 4 || r == 5);
            az = (r == 3 || r == 4 || r == 7);
            cycle(s, j, jr, jal, an, az, $urandom);
            if (got_ra !== want_ra) begin
                miscompares++;
                $display("FAIL rnd_ra_%0d got %b want %b", n, got_ra, want_ra);
            end
            vectors++;
            if (instr_addr !== m_pc || ir_valid !== m_valid ||
                instr_out !== m_ir || halted !== m_halt) begin
                miscompares++;
                $display("FAIL rnd_state_%0d got addr=%h ir=%h v=%b h=%b want %h/%h/%b/%b",
                         n, instr_addr, instr_out, ir_valid, halted,
                         m_pc, m_ir, m_valid, m_halt);
            end
            vectors++;
            if (m_valid && ir_pc_plus4 !== m_irpc + 32'd4) begin
                miscompares++;
                $display("FAIL rnd_p4_%0d got %h want %h", n, ir_pc_plus4,
                         m_irpc + 32'd4);
            end
            vectors++;
        end
    endtask

    task automatic test_halt();
        patch.delete();
        patch[32'h8] = 32'hFC00_0000;
        do_reset();
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        if (halted !== 1'b1 || instr_addr !== 32'h0C || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_enter got h=%b addr=%h v=%b want 1/0c/0",
                     halted, instr_addr, ir_valid);
        end
        vectors++;
        for (int k = 0; k < 10; k++) begin
            cycle(1'($urandom), 1, 1'($urandom), 1, 1, 1, $urandom);
            if (halted !== 1'b1 || instr_addr !== 32'h0C ||
                ir_valid !== 1'b0 || got_ra !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold_%0d got h=%b addr=%h v=%b ra=%b want 1/0c/0/0",
                         k, halted, instr_addr, ir_valid, got_ra);
            end
            vectors++;
        end
        #2 reset = 1'b1;
        #1;
        if (instr_addr !== 32'd0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset got addr=%h h=%b want 0/0",
                     instr_addr, halted);
        end
        vectors++;
        @(negedge clock);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        if (instr_addr !== 32'd4 || ir_valid !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_restart got addr=%h v=%b h=%b want 4/1/0",
                     instr_addr, ir_valid, halted);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_jumpreg();
        test_stall();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, 6'b111111, opcode that freezes fetch.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 stall  in  1  hazard hold; freezes PC and IR when high.
REQ-006 Jump, JumpReg, Jal, And  in  1 each  decode flags for the instruction currently in IR.
REQ-007 AluZero  in  1  branch condition true for IR's branch (qualified by And).
REQ-008 RegAddr  in  32  rs value; JR target.
REQ-009 instr_in  in  32  instruction-memory read data for instr_addr, combinational, same cycle.
REQ-010 instr_addr  out  32  current PC, byte address, word aligned.
REQ-011 instr_out  out  32  IR; instr_out[31:26] drives the decoder opcode.
REQ-012 ir_pc_plus4  out  32  address of IR instruction + 4.
REQ-013 ir_valid  out  1  IR holds a real instruction, not a bubble.
REQ-014 ra_write  out  1  one-cycle request to write ir_pc_plus4 into reg[31].
REQ-015 halted  out  1  fetch frozen by HALT_OPCODE.

Function
REQ-016 States RUN and HALT; reset -> RUN.
REQ-017 In RUN with stall=0, each edge: IR<=instr_in, ir_pc<=PC, ir_valid<=1, PC<=next_pc.
REQ-018 Redirect is evaluated only when ir_valid=1, stall=0, state RUN.
REQ-019 next_pc priority: JumpReg -> RegAddr; else Jump -> {ir_pc_plus4[31:28], instr_out[25:0], 2'b00}; else (And & AluZero) -> ir_pc_plus4 + (sign-extended instr_out[15:0] << 2); else PC+4.
REQ-020 On any redirect (JumpReg, Jump, or taken branch), the edge loads IR with a bubble: ir_valid<=0, instr_out<=0; the fetched sequential word is discarded (one-cycle penalty).
REQ-021 And=1 with AluZero=0 is not a redirect; sequential fetch continues, no bubble.
REQ-022 ra_write = ir_valid & Jal & Jump & ~stall & state RUN; combinational, one cycle per JAL.
REQ-023 All address arithmetic modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0; RegAddr[1:0] forced to 00.
REQ-024 stall=1: PC, IR, ir_pc, ir_valid held; redirect and ra_write suppressed; flags re-evaluated when stall drops.
REQ-025 RUN -> HALT when ir_valid=1, instr_out[31:26]=HALT_OPCODE, stall=0; the edge also loads a bubble and holds PC.
REQ-026 In HALT: PC held, ir_valid=0, ra_write=0, halted=1; only reset exits.
REQ-027 Flags with ir_valid=0 are ignored.

Reset
REQ-028 On reset assertion, asynchronously: PC=RESET_PC, instr_out=0, ir_pc=0, ir_valid=0, state=RUN, halted=0, ra_write=0.
REQ-029 Reset mid-redirect or mid-stall discards the pending action; first fetch after release is RESET_PC.
REQ-030 First edge after reset release loads IR from RESET_PC with ir_valid=1 unless stall=1.

Verification
REQ-031 Reset release, stall=0, no flags, 3 edges -> instr_addr 0,4,8,12; ir_valid=1 from edge 1; ir_pc_plus4 = 4,8,12.
REQ-032 IR at 0x10, And=1, AluZero=1, instr_out[15:0]=16'hFFFE -> next instr_addr 0x0C, ir_valid=0 one cycle; AluZero=0 -> 0x18, no bubble.
REQ-033 IR at 0x20 JAL, Jump=Jal=1, instr_out[25:0]=26'h40 -> ra_write=1 one cycle with ir_pc_plus4=0x24, next instr_addr 0x100.
REQ-034 JumpReg=1 and Jump=1 together, RegAddr=0x203 -> next instr_addr 0x200 (JumpReg wins, low bits cleared).
REQ-035 Branch-taken flags with stall=1 for 2 cycles -> PC/IR frozen, ra_write=0; stall drops -> redirect taken once.
REQ-036 IR opcode 6'b111111 -> halted=1 next edge, instr_addr constant over 10 cycles; assert reset mid-halt -> instr_addr=RESET_PC immediately, halted=0.
